// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller, the hazard unit and the datapath.
// Contents: controller state encoding, the INIT sequence length and the
// performance-counter width.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pipe_state_e;

    // Number of cycles spent in INIT after reset, flushing every stage register.
    localparam int INIT_CYCLES = 4;
    localparam int INIT_CNT_W  = 2;
    localparam int CNT_W       = 16;

    // Load value of the INIT down-counter: INIT ends on the edge where it reads 0.
    localparam logic [INIT_CNT_W-1:0] INIT_CNT_RST = INIT_CNT_W'(INIT_CYCLES - 1);

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle between the hazard/stage logic and pipe_ctrl.
// slave  : pipe_ctrl side (takes requests, drives enables/flushes/status).
// master : pipeline side (drives requests, takes enables/flushes/status).
// Requests : hz_stall, ex_redirect, if_busy, mem_busy, halt_req, resume, cnt_clr.
// Controls : pc/ifid/idex/exmem/memwb enables, ifid/idex/exmem/memwb flushes.
// Status   : halted, stall_cnt, flush_cnt.
interface pipe_ctrl_if;
    import pipe_pkg::*;

    logic             hz_stall;
    logic             ex_redirect;
    logic             if_busy;
    logic             mem_busy;
    logic             halt_req;
    logic             resume;
    logic             cnt_clr;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  hz_stall, ex_redirect, if_busy, mem_busy, halt_req, resume, cnt_clr,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, exmem_flush, memwb_flush,
        output halted, stall_cnt, flush_cnt
    );

    modport master (
        output hz_stall, ex_redirect, if_busy, mem_busy, halt_req, resume, cnt_clr,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, exmem_flush, memwb_flush,
        input  halted, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst_n (async active-low), inc (count this cycle),
//        clr (zero on next edge, wins over inc), cnt (current value).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: sequences the post-reset flush, arbitrates
// halt / memory stall / redirect / load-use stall / fetch stall into stage
// enables and flushes, and keeps saturating stall and flush counters.
// Ports: clk, rst_n (async active-low), pif (pipe_ctrl_if.slave bundle).
module pipe_ctrl
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.slave  pif
);

    pipe_state_e           state_q, state_d;
    logic [INIT_CNT_W-1:0] init_cnt_q, init_cnt_d;
    logic                  stall_inc;
    logic                  flush_inc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= INIT_CNT_RST;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        unique case (state_q)
            ST_INIT: begin
                if (init_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q - INIT_CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (pif.halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (pif.resume) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Output decode: combinational from state and current requests.
    always_comb begin
        pif.pc_en       = 1'b1;
        pif.ifid_en     = 1'b1;
        pif.idex_en     = 1'b1;
        pif.exmem_en    = 1'b1;
        pif.memwb_en    = 1'b1;
        pif.ifid_flush  = 1'b0;
        pif.idex_flush  = 1'b0;
        pif.exmem_flush = 1'b0;
        pif.memwb_flush = 1'b0;
        pif.halted      = 1'b0;
        stall_inc       = 1'b0;
        flush_inc       = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (pif.halt_req) begin
                    // Younger instructions are squashed; the halting one in WB retires.
                    pif.pc_en       = 1'b0;
                    pif.ifid_flush  = 1'b1;
                    pif.idex_flush  = 1'b1;
                    pif.exmem_flush = 1'b1;
                end else if (pif.mem_busy) begin
                    // Freeze IF..EX (a pending redirect waits in EX) and bubble WB.
                    pif.pc_en       = 1'b0;
                    pif.ifid_en     = 1'b0;
                    pif.idex_en     = 1'b0;
                    pif.exmem_en    = 1'b0;
                    pif.memwb_flush = 1'b1;
                    stall_inc       = 1'b1;
                end else if (pif.ex_redirect) begin
                    // IF and ID hold wrong-path instructions, so any stall on them is moot.
                    pif.ifid_flush  = 1'b1;
                    pif.idex_flush  = 1'b1;
                    flush_inc       = 1'b1;
                end else if (pif.hz_stall) begin
                    pif.pc_en       = 1'b0;
                    pif.ifid_en     = 1'b0;
                    pif.idex_flush  = 1'b1;
                    stall_inc       = 1'b1;
                end else if (pif.if_busy) begin
                    pif.pc_en       = 1'b0;
                    pif.ifid_flush  = 1'b1;
                    stall_inc       = 1'b1;
                end
            end
            ST_HALT: begin
                pif.pc_en       = 1'b0;
                pif.ifid_en     = 1'b0;
                pif.idex_en     = 1'b0;
                pif.exmem_en    = 1'b0;
                pif.memwb_en    = 1'b0;
                pif.halted      = 1'b1;
            end
            default: begin
                // INIT: hold the PC and load bubbles into every stage.
                pif.pc_en       = 1'b0;
                pif.ifid_flush  = 1'b1;
                pif.idex_flush  = 1'b1;
                pif.exmem_flush = 1'b1;
                pif.memwb_flush = 1'b1;
            end
        endcase
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .clr   (pif.cnt_clr),
        .cnt   (pif.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .clr   (pif.cnt_clr),
        .cnt   (pif.flush_cnt)
    );

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk in, rst_n in.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 hz_stall  input  1  load-use stall request from the hazard unit, for the ID instruction.
REQ-005 ex_redirect  input  1  taken branch or jump resolved in EX.
REQ-006 if_busy  input  1  instruction fetch not ready this cycle.
REQ-007 mem_busy  input  1  data access in MEM not complete this cycle.
REQ-008 halt_req  input  1  halting instruction (ecall/ebreak) is in WB.
REQ-009 resume  input  1  leave HALT; single-cycle pulse.
REQ-010 cnt_clr  input  1  synchronous clear of both counters.
REQ-011 pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  stage-register load enables.
REQ-012 ifid_flush, idex_flush, exmem_flush, memwb_flush  output  1 each  load a NOP/invalid into the register when its enable is 1.
REQ-013 halted  output  1  high while in HALT.
REQ-014 stall_cnt, flush_cnt  output  16 each  saturating performance counters.

Function
REQ-015 FSM states SHALL be INIT, RUN, HALT; output decode is combinational from state and inputs, with no input-to-output latency.
REQ-016 INIT outputs: pc_en=0, other enables=1, all flushes=1, halted=0; a 2-bit init_cnt counts 3 down to 0; the state moves to RUN on the edge where init_cnt=0 (exactly 4 INIT cycles).
REQ-017 RUN SHALL apply the first matching rule, in this priority order:
 (1) halt_req: pc_en=0, ifid/idex/exmem flush with their enables=1, memwb_en=1 with no flush (the halting instruction retires); next state HALT.
 (2) mem_busy: pc/ifid/idex/exmem enables=0, memwb_en=1 with memwb_flush=1.
 (3) ex_redirect: all enables=1, ifid_flush=1, idex_flush=1.
 (4) hz_stall: pc_en=0, ifid_en=0, idex_flush=1, other enables=1.
 (5) if_busy: pc_en=0, ifid_flush=1, all other enables=1.
 (6) otherwise: all enables=1, no flush.
REQ-018 ex_redirect SHALL override hz_stall and if_busy, because the ID and IF instructions are wrong-path.
REQ-019 mem_busy SHALL override ex_redirect; the redirect stays asserted because EX is frozen, and it takes effect on the first cycle mem_busy=0.
REQ-020 HALT: all enables=0, all flushes=0, halted=1; resume moves the state to RUN on the next edge, and the PC value is preserved.
REQ-021 halt_req SHALL be ignored in HALT and INIT; resume SHALL be ignored outside HALT.
REQ-022 stall_cnt SHALL increment by 1 in each RUN cycle where rule 2, 4 or 5 applies; flush_cnt SHALL increment on each rule-3 cycle.
REQ-023 Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-024 cnt_clr SHALL zero both counters on the next edge, with priority over increment.

Reset
REQ-025 While rst_n=0: state=INIT, init_cnt=3, counters=0, and outputs immediately take the INIT values (pc_en=0, other enables=1, flushes=1, halted=0); reset asserted mid-stall or in HALT SHALL abort to INIT with no residual state.
REQ-026 After rst_n deasserts, RUN is entered after exactly 4 clk edges.

Structure
REQ-027 Package pipe_pkg SHALL hold the state enum, INIT_CYCLES=4 and CNT_W=16; the hazard unit and datapath share it.
REQ-028 A sub-module sat_counter (width parameter, inc, clr) SHALL be instantiated twice, for stall_cnt and flush_cnt.

Verification
REQ-029 Release reset, no requests -> 4 cycles of pc_en=0 with all flushes=1, then RUN with all enables=1 and flushes=0.
REQ-030 hz_stall=1 and ex_redirect=1 in the same cycle -> pc_en=1, ifid_flush=1, idex_flush=1; flush_cnt+1, stall_cnt unchanged.
REQ-031 mem_busy=1 for 3 cycles with ex_redirect=1 -> 3 cycles of pc..exmem enables=0 and memwb_flush=1, stall_cnt+3; next cycle rule-3 outputs.
REQ-032 halt_req pulse -> ifid/idex/exmem flush; halted=1 from the next cycle; resume pulse -> RUN one cycle later; a halt_req during HALT is ignored.
REQ-033 Force stall_cnt to 16'hFFFE, hold hz_stall 3 cycles -> counter reads FFFF and stays; cnt_clr together with hz_stall -> counter reads 0.
REQ-034 Assert rst_n=0 mid-HALT -> halted=0 and INIT outputs without waiting for a clock edge.
